buzzer_arbiter: RTL and testbench

//  Shares the single piezo buzzer output among NREQ requesters (alarm, siren, UI beeps).

---
 rtl/buzzer_arbiter.sv | 152 +++++++++++++++
 tb/tb_buzzer_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// Purpose : round-robin share of one piezo buzzer among NREQ tone requesters.
// Latency : grant 1 cycle after req is seen in IDLE; a fixed silent gap follows every note.
// Backpressure: requesters hold req until done/abort; req is only sampled while IDLE.
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   req            per-requester request level
//   div / dur      packed per-requester half-period divider (0 = rest) and note length
//   gnt            one-hot grant, high for the whole note
//   done           one-cycle pulse on the granted bit after a note completes normally
//   busy           high while playing or in the silent gap
//   PIN_10         buzzer square wave
module buzzer_arbiter #(
  parameter int NREQ       = 4,
  parameter int DIV_W      = 15,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 16000
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DIV_W-1:0]   div,
  input  logic [NREQ*DUR_W-1:0]   dur,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    PIN_10
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Gap counter counts down to 0, so it is loaded with one less than the gap length.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   winner;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   tone_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               pin;
  logic [NREQ-1:0]    done_q;

  logic               any_req;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [DIV_W-1:0]   pick_div;
  logic [DUR_W-1:0]   pick_dur;
  logic               abort;
  logic               last_play;

  // Round-robin pick: first set request at or after ptr, wrapping.
  always_comb begin
    any_req = |req;
    found   = 1'b0;
    pick    = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = PTR_W'((int'(ptr) + i) % NREQ);
      end
    end
    pick_div = div[int'(pick)*DIV_W +: DIV_W];
    pick_dur = dur[int'(pick)*DUR_W +: DUR_W];
    ptr_nxt  = (pick == PTR_W'(NREQ - 1)) ? '0 : pick + PTR_W'(1);
  end

  assign abort     = ~req[winner];
  assign last_play = (dur_cnt == DUR_W'(1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = PLAY;
      end
      PLAY: begin
        gnt  = NREQ'(1) << winner;
        busy = 1'b1;
        if (abort || last_play) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr      <= '0;
      winner   <= '0;
      div_q    <= '0;
      tone_cnt <= '0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      pin      <= 1'b0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            winner   <= pick;
            ptr      <= ptr_nxt;
            div_q    <= pick_div;
            tone_cnt <= pick_div;
            // A zero duration still plays for one cycle.
            dur_cnt  <= (pick_dur == '0) ? DUR_W'(1) : pick_dur;
            pin      <= 1'b0;
          end
        end
        PLAY: begin
          if (abort || last_play) begin
            pin     <= 1'b0;
            gap_cnt <= GAP_LOAD;
            // A dropped request ends the note silently, even on its last cycle.
            if (!abort) done_q <= NREQ'(1) << winner;
          end else begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (tone_cnt == '0) begin
              tone_cnt <= div_q;
              // div 0 is a rest: the counter sits at 0 but the pin never toggles.
              if (div_q != '0) pin <= ~pin;
            end else begin
              tone_cnt <= tone_cnt - DIV_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign done   = done_q;
  assign PIN_10 = pin;

endmodule

// File: tb/tb_buzzer_arbiter.sv
module tb_buzzer_arbiter;

  localparam int NREQ  = 4;
  localparam int DIV_W = 15;
  localparam int DUR_W = 24;
  localparam int GAPC  = 4;

  logic                  CLK = 1'b0;
  logic                  RESET_N;
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div;
  logic [NREQ*DUR_W-1:0] dur;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  PIN_10;

  buzzer_arbiter #(
    .NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYCLES(GAPC)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .div(div), .dur(dur),
    .gnt(gnt), .done(done), .busy(busy), .PIN_10(PIN_10)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int bad_grant = 0;
  int exp_q[$];
  int m_wait, m_len, m_rises, m_first, m_high, m_done, m_pin, m_busy;
  int g_busy, g_done;
  logic [NREQ-1:0] prev_gnt = '0;

  // Grant must be one-hot and never hand over directly between requesters.
  always @(negedge CLK) begin
    if (gnt !== '0 && !$onehot(gnt)) bad_grant <= bad_grant + 1;
    if (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt) bad_grant <= bad_grant + 1;
    prev_gnt <= gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input int obs);
    int e;
    vectors++;
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic set_tone(input int i, input int d, input int u);
    div[i*DIV_W +: DIV_W] = DIV_W'(d);
    dur[i*DUR_W +: DUR_W] = DUR_W'(u);
  endtask

  task automatic wait_gnt(input int budget);
    m_wait = 0;
    while (gnt == '0 && m_wait < budget) begin
      @(negedge CLK);
      m_wait++;
    end
  endtask

  // Follows one grant until it drops; records length, pin activity and the exit cycle.
  task automatic measure(input int budget, input int abort_at, input int chg_at, input int chg_idx);
    logic [NREQ-1:0] g;
    logic prev;
    g = gnt; prev = 1'b0;
    m_len = 0; m_rises = 0; m_first = -1; m_high = 0;
    while (gnt == g && g != '0 && m_len < budget) begin
      if (PIN_10 === 1'b1) begin
        m_high++;
        if (!prev) begin
          m_rises++;
          if (m_first < 0) m_first = m_len;
        end
      end
      prev = PIN_10;
      if (m_len == chg_at) set_tone(chg_idx, 9, 3);
      if (m_len == abort_at) req = '0;
      m_len++;
      @(negedge CLK);
    end
    m_done = int'(done);
    m_pin  = int'(PIN_10);
    m_busy = int'(busy);
  endtask

  task automatic gap_count(input int budget);
    g_busy = 0; g_done = 0;
    while (busy && g_busy < budget) begin
      if (done != '0) g_done++;
      g_busy++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    RESET_N = 1'b0; req = '0; div = '0; dur = '0;
    repeat (3) @(negedge CLK);
    push(0); push(0); push(0); push(0);
    chk("rst_gnt", int'(gnt));
    chk("rst_done", int'(done));
    chk("rst_busy", int'(busy));
    chk("rst_pin", int'(PIN_10));
    RESET_N = 1'b1;
    @(negedge CLK);

    // 1: single tone, div 7 / dur 64, gap 4
    set_tone(0, 7, 64); req = 4'b0001;
    push(1); push(1); push(64); push(4); push(8); push(32); push(1); push(0); push(4); push(1);
    wait_gnt(20);
    chk("t1_latency", m_wait);
    chk("t1_gnt", int'(gnt));
    measure(500, -1, -1, 0);
    chk("t1_play_len", m_len);
    chk("t1_rises", m_rises);
    chk("t1_first_rise", m_first);
    chk("t1_high_cycles", m_high);
    chk("t1_done", m_done);
    chk("t1_pin_after", m_pin);
    req = '0;
    gap_count(50);
    chk("t1_gap_busy", g_busy);
    chk("t1_done_pulses", g_done);

    // 2: all requesting from reset, round-robin order 0,1,2,3,0
    RESET_N = 1'b0;
    for (int i = 0; i < NREQ; i++) set_tone(i, 1, 10);
    req = 4'b1111;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int n = 0; n < 5; n++) begin
      push(1 << (n % 4)); push(10); push(1 << (n % 4));
      wait_gnt(30);
      chk("t2_gnt_order", int'(gnt));
      measure(100, -1, -1, 0);
      chk("t2_play_len", m_len);
      chk("t2_done", m_done);
    end
    req = '0;
    wait_idle(50);

    // 3: rest note on requester 1; input changes mid-note must be ignored
    set_tone(1, 0, 20); req = 4'b0010;
    push(1); push(20); push(0); push(0); push(2);
    wait_gnt(20);
    chk("t3_latency", m_wait);
    measure(100, -1, 5, 1);
    chk("t3_play_len", m_len);
    chk("t3_rises", m_rises);
    chk("t3_high_cycles", m_high);
    chk("t3_done", m_done);
    req = '0;
    wait_idle(50);

    // 4: abort requester 2 after 100 granted cycles
    set_tone(2, 5, 1000); req = 4'b0100;
    push(1); push(101); push(0); push(0); push(1); push(4); push(0);
    wait_gnt(20);
    chk("t4_latency", m_wait);
    measure(2000, 100, -1, 0);
    chk("t4_play_len", m_len);
    chk("t4_done", m_done);
    chk("t4_pin_after", m_pin);
    chk("t4_busy_gap", m_busy);
    gap_count(50);
    chk("t4_gap_busy", g_busy);
    chk("t4_done_pulses", g_done);

    // 5: asynchronous reset while the pin is high; pointer returns to 0
    set_tone(0, 3, 200); req = 4'b0001;
    push(1); push(1); push(0); push(0); push(0); push(0); push(1); push(1); push(200);
    wait_gnt(20);
    chk("t5_latency", m_wait);
    begin
      int n;
      n = 0;
      while (PIN_10 !== 1'b1 && n < 50) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("t5_pin_high", int'(PIN_10));
    RESET_N = 1'b0;
    #1;
    chk("t5_rst_pin", int'(PIN_10));
    chk("t5_rst_gnt", int'(gnt));
    chk("t5_rst_busy", int'(busy));
    chk("t5_rst_done", int'(done));
    req = 4'b1111;
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_gnt(20);
    chk("t5_latency2", m_wait);
    chk("t5_gnt_req0", int'(gnt));
    measure(500, -1, -1, 0);
    chk("t5_play_len", m_len);
    req = '0;
    wait_idle(50);

    // 6: zero duration plays exactly one cycle
    set_tone(3, 3, 0); req = 4'b1000;
    push(1); push(1); push(0); push(8); push(4); push(1);
    wait_gnt(20);
    chk("t6_latency", m_wait);
    measure(100, -1, -1, 0);
    chk("t6_play_len", m_len);
    chk("t6_rises", m_rises);
    chk("t6_done", m_done);
    req = '0;
    gap_count(50);
    chk("t6_gap_busy", g_busy);
    chk("t6_done_pulses", g_done);

    push(0);
    chk("grant_onehot", bad_grant);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
